alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; only 8 is required to be supported.
REQ-002 Ports, in order:
- clk  in  1  rising-edge clock; the single clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_sel  in  3  ALU op code.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_acc  in  1  take A from the accumulator (see Configuration).
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_sel  out  3  ALU op select.
- alu_out  in  WIDTH  ALU result.
- alu_uovf  in  1  ALU unsigned overflow.
- alu_sovf  in  1  ALU signed overflow.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  WIDTH  captured result.
- res_uovf  out  1  unsigned overflow of this result.
- res_sovf  out  1  signed overflow of this result.
- sticky_uovf  out  1  OR of all res_uovf since the last clear.
- sticky_sovf  out  1  OR of all res_sovf since the last clear.
- flag_clr  in  1  clear both sticky flags.

Function
REQ-003 State machine SHALL have three states, IDLE, EXEC and HOLD, and only these transitions:
- IDLE -> EXEC on cmd_valid.
- EXEC -> HOLD unconditionally.
- HOLD -> IDLE on res_ready.
REQ-004 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1.
REQ-005 On accept, sel, A and B SHALL be registered; alu_a, alu_b and alu_sel SHALL drive these registers and hold them stable until the next accept.
REQ-006 At the end of EXEC, the block SHALL capture alu_out into res_data; result latency is 2 cycles from the accept edge to res_valid=1.
REQ-007 The captured res_uovf and res_sovf SHALL be alu_uovf and alu_sovf when sel is 3'b100 or 3'b101, and 0 for every other sel.
REQ-008 res_valid SHALL be 1 only in HOLD; res_data and the res flags SHALL stay stable while res_valid=1 and res_ready=0.
REQ-009 Throughput: when res_ready is held at 1, one command completes every 3 cycles; a back-to-back cmd_valid waits in IDLE.
REQ-010 On the EXEC->HOLD edge, sticky flags SHALL OR in the newly captured res flags.
REQ-011 flag_clr SHALL zero both sticky flags on the next edge; if a set and a clear happen in the same cycle, the set wins.
REQ-012 cmd_* inputs SHALL be ignored outside IDLE; changing them during EXEC or HOLD has no effect.

Reset
REQ-013 With rst=1 at a clock edge, the block SHALL enter IDLE and set all of the following to 0: the state register, operand registers, sel register, res_data, res_uovf, res_sovf, sticky flags and accumulator.
REQ-014 Reset SHALL override any state, including mid-EXEC or HOLD; a pending result is discarded with no res_valid pulse.
REQ-015 After reset, cmd_ready=1 in the first cycle in which rst=0.

Configuration
REQ-016 Macro ALU_ISSUE_ACC_EN selects accumulator chaining.
REQ-017 With ALU_ISSUE_ACC_EN defined:
- an accumulator register SHALL load res_data on every capture;
- an accept with cmd_acc=1 SHALL register the accumulator value as operand A instead of cmd_a.
REQ-018 Without ALU_ISSUE_ACC_EN: there is no accumulator register, cmd_acc SHALL be ignored, and the port SHALL still exist.

Structure
REQ-019 Shared package alu_pkg SHALL hold:
- op-code constants: PASS=000, MUL=001, OR=010, NOT=011, ADD=100, SUB=101, INC=110, DEC=111;
- the alu_issue state enum.
REQ-020 No sub-module SHALL be used; the ALU is instantiated beside this block by the parent, not inside it.

Verification
REQ-021 The bench SHALL cover these scenarios:
- ADD a=8'h7F b=8'h01, res_ready=1 -> res_valid 2 cycles after accept; res_data=8'h80, res_sovf=1, res_uovf=0, sticky_sovf=1.
- ADD a=8'hFF b=8'h01 -> res_data=8'h00, res_uovf=1; then OR a=8'hF0 b=8'h0F -> res_data=8'hFF, res flags 0, sticky_uovf remains 1.
- res_ready=0 for 5 cycles in HOLD -> res_valid, res_data and flags stable, cmd_ready=0; res_ready=1 -> IDLE next cycle.
- flag_clr=1 in the same cycle as the EXEC->HOLD edge of an overflowing ADD -> sticky flag reads 1.
- rst=1 during EXEC -> next cycle: IDLE, all outputs 0, no res_valid.
- With ALU_ISSUE_ACC_EN: INC a=8'h05, then INC with cmd_acc=1 and cmd_a=8'hAA -> second res_data=8'h07.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage and its neighbours:
//   - op-code constants for the 3-bit ALU select
//   - the alu_issue state encoding
//   - a helper telling which op codes report overflow to the consumer
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] PASS = 3'b000;
  localparam logic [2:0] MUL  = 3'b001;
  localparam logic [2:0] OR   = 3'b010;
  localparam logic [2:0] NOT  = 3'b011;
  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] SUB  = 3'b101;
  localparam logic [2:0] INC  = 3'b110;
  localparam logic [2:0] DEC  = 3'b111;

  // IDLE is all-zero so a cleared state register means IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } alu_issue_state_e;

  // Only the add/subtract ops forward the ALU overflow flags; every other op
  // reports no overflow regardless of what the ALU drives.
  function automatic logic flags_apply(input logic [2:0] sel);
    return (sel == ADD) || (sel == SUB);
  endfunction

endpackage

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
// Issue/capture stage wrapped around an external combinational ALU. A command
// is accepted in IDLE, its operands are held on alu_a/alu_b/alu_sel through
// EXEC, the ALU result is captured at the end of EXEC and offered to the
// consumer in HOLD until res_ready. Sticky flags accumulate overflow reports.
//
// Optional feature: define ALU_ISSUE_ACC_EN to add an accumulator that
// follows every captured result and can replace operand A (cmd_acc=1).
// Without it, cmd_acc is present but ignored.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready          command handshake (ready only in IDLE)
//   cmd_sel/a/b/acc          command op code, operands, accumulator select
//   alu_a/b/sel              registered operands toward the external ALU
//   alu_out/uovf/sovf        ALU result and overflow flags
//   res_valid/ready          result handshake (valid only in HOLD)
//   res_data/uovf/sovf       captured result and its overflow flags
//   sticky_uovf/sovf         OR of result flags since the last clear
//   flag_clr                 clear both sticky flags
// -----------------------------------------------------------------------------
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_sel,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_uovf,
  input  logic             alu_sovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_uovf,
  output logic             res_sovf,
  output logic             sticky_uovf,
  output logic             sticky_sovf,
  input  logic             flag_clr
);

  alu_issue_state_e state;
  alu_issue_state_e state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] op_a_next;
  logic             accept;
  logic             capture;
  logic             new_uovf;
  logic             new_sovf;

  // cmd_* are only looked at in IDLE, so they cannot disturb EXEC or HOLD.
  assign accept  = (state == IDLE) && cmd_valid;
  assign capture = (state == EXEC);

  assign new_uovf = capture && flags_apply(op_sel) && alu_uovf;
  assign new_sovf = capture && flags_apply(op_sel) && alu_sovf;

`ifdef ALU_ISSUE_ACC_EN
  logic [WIDTH-1:0] acc;

  // Operand A source: accumulator when chaining is requested.
  always_comb begin
    op_a_next = cmd_a;
    if (cmd_acc) begin
      op_a_next = acc;
    end else begin
      op_a_next = cmd_a;
    end
  end

  // Accumulator follows every captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= {WIDTH{1'b0}};
    end else if (capture) begin
      acc <= alu_out;
    end
  end
`else
  logic unused_cmd_acc;
  assign unused_cmd_acc = cmd_acc;
  assign op_a_next      = cmd_a;
`endif

  // Next-state decode: IDLE -> EXEC -> HOLD -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_next = EXEC;
        end else begin
          state_next = IDLE;
        end
      end
      EXEC: state_next = HOLD;
      HOLD: begin
        if (res_ready) begin
          state_next = IDLE;
        end else begin
          state_next = HOLD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State plus handshake outputs, registered straight from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_ready <= (state_next == IDLE);
      res_valid <= (state_next == HOLD);
    end
  end

  // Operand registers feeding the ALU, held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= {WIDTH{1'b0}};
      op_b   <= {WIDTH{1'b0}};
      op_sel <= 3'b000;
    end else if (accept) begin
      op_a   <= op_a_next;
      op_b   <= cmd_b;
      op_sel <= cmd_sel;
    end
  end

  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_sel = op_sel;

  // Result capture at the end of EXEC; stable through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data <= {WIDTH{1'b0}};
      res_uovf <= 1'b0;
      res_sovf <= 1'b0;
    end else if (capture) begin
      res_data <= alu_out;
      res_uovf <= new_uovf;
      res_sovf <= new_sovf;
    end
  end

  // Sticky flags: a capture that sets a flag beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_uovf <= 1'b0;
      sticky_sovf <= 1'b0;
    end else begin
      sticky_uovf <= (flag_clr ? 1'b0 : sticky_uovf) | new_uovf;
      sticky_sovf <= (flag_clr ? 1'b0 : sticky_sovf) | new_sovf;
    end
  end

endmodule
